// File: rtl/bpt_update_queue.sv
// bpt_update_queue: small circular FIFO between branch resolution and the
// branch-prediction-table update port. The head entry drives the update
// outputs combinationally and is consumed when the table signals upd_ready.
// Saturating statistics counters track resolved branches, mispredicts and
// updates dropped because the queue was full.
module bpt_update_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       br_valid,
    input  logic [PC_W-1:0]            br_pc,
    input  logic                       br_taken,
    input  logic                       br_pred_taken,
    input  logic                       flush,
    input  logic                       clr_stats,
    input  logic                       upd_ready,
    output logic                       enable_res,
    output logic [PC_W-1:0]            pc_res,
    output logic                       taken_res,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [CNT_W-1:0]           br_cnt,
    output logic [CNT_W-1:0]           mispred_cnt,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    // Entry storage; validity is defined purely by the pointers.
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic            taken_mem [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;

    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic empty;
    logic full;
    logic pop_req;
    logic pop;
    logic push;
    logic drop;
    logic mispred;

    assign empty   = (rd_ptr_q == wr_ptr_q);
    assign full    = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) &&
                     (rd_ptr_q[AW] != wr_ptr_q[AW]);
    // A pop frees a slot for a same-cycle push even when the queue is full.
    assign pop_req = !empty && upd_ready;
    assign pop     = pop_req && !flush;
    assign push    = br_valid && !flush && (!full || pop_req);
    assign drop    = br_valid && !flush && full && !pop_req;
    assign mispred = br_valid && (br_taken != br_pred_taken);

    // Head entry is presented without any registering; zeros when empty.
    always_comb begin
        enable_res = !empty;
        pc_res     = '0;
        taken_res  = 1'b0;
        if (!empty) begin
            pc_res    = pc_mem[rd_ptr_q[AW-1:0]];
            taken_res = taken_mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign q_count     = wr_ptr_q - rd_ptr_q;
    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
    assign drop_cnt    = drop_cnt_q;

    // Pointer and counter next-state; flush empties by catching rd up to wr.
    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        drop_cnt_d    = drop_cnt_q;

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (clr_stats) begin
            br_cnt_d      = '0;
            mispred_cnt_d = '0;
            drop_cnt_d    = '0;
        end else begin
            if (br_valid && (br_cnt_q != '1)) begin
                br_cnt_d = br_cnt_q + 1'b1;
            end
            if (mispred && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + 1'b1;
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Tail write; the storage itself is never reset.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            pc_mem[wr_ptr_q[AW-1:0]]    <= br_pc;
            taken_mem[wr_ptr_q[AW-1:0]] <= br_taken;
        end
    end

endmodule

// File: tb/tb_bpt_update_queue.sv
// Bench for bpt_update_queue: a queue-based reference model is compared to
// the DUT on every falling edge, and directed tests pin key values literally.
module tb_bpt_update_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 32;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            br_valid = 1'b0;
    logic [PC_W-1:0] br_pc = '0;
    logic            br_taken = 1'b0;
    logic            br_pred_taken = 1'b0;
    logic            flush = 1'b0;
    logic            clr_stats = 1'b0;
    logic            upd_ready = 1'b0;
    logic            enable_res;
    logic [PC_W-1:0] pc_res;
    logic            taken_res;
    logic [2:0]      q_count;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    logic [CNT_W-1:0] drop_cnt;

    bpt_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .br_valid(br_valid), .br_pc(br_pc),
        .br_taken(br_taken), .br_pred_taken(br_pred_taken), .flush(flush),
        .clr_stats(clr_stats), .upd_ready(upd_ready), .enable_res(enable_res),
        .pc_res(pc_res), .taken_res(taken_res), .q_count(q_count),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt), .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of {taken, pc} plus counters.
    logic [PC_W:0] m_q[$];
    longint m_br = 0, m_mis = 0, m_drop = 0;
    logic [PC_W-1:0] dut_emit[$];

    always @(posedge CLK) begin
        // Record what the DUT hands to the table this edge (pre-update values).
        if (!RST && enable_res && upd_ready && !flush) dut_emit.push_back(pc_res);

        if (RST) begin
            m_q.delete();
            m_br = 0; m_mis = 0; m_drop = 0;
        end else begin
            if (flush) begin
                m_q.delete();
            end else begin
                if (m_q.size() > 0 && upd_ready) void'(m_q.pop_front());
                if (br_valid) begin
                    if (m_q.size() < DEPTH) m_q.push_back({br_taken, br_pc});
                    else if (!clr_stats && m_drop < CMAX) m_drop++;
                end
            end
            if (clr_stats) begin
                m_br = 0; m_mis = 0; m_drop = 0;
            end else begin
                if (br_valid && m_br < CMAX) m_br++;
                if (br_valid && br_taken != br_pred_taken && m_mis < CMAX) m_mis++;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_enable", enable_res, (m_q.size() > 0) ? 1 : 0);
            chk("m_pc", pc_res, (m_q.size() > 0) ? m_q[0][PC_W-1:0] : 0);
            chk("m_taken", taken_res, (m_q.size() > 0) ? m_q[0][PC_W] : 0);
            chk("m_qcount", q_count, m_q.size());
            chk("m_brcnt", br_cnt, m_br);
            chk("m_mispred", mispred_cnt, m_mis);
            chk("m_drop", drop_cnt, m_drop);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic t,
                         input logic pt);
        br_valid = v; br_pc = pc; br_taken = t; br_pred_taken = pt;
    endtask

    int k;
    int sz;

    initial begin
        // Reset
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        chk_en = 1'b1;
        chk("rst_enable", enable_res, 0);
        chk("rst_qcount", q_count, 0);
        chk("rst_pc", pc_res, 0);
        chk("rst_brcnt", br_cnt, 0);

        // Test 1: single push, visible next cycle, popped the one after
        upd_ready = 1'b1;
        drive(1, 32'h40, 1, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("t1_enable", enable_res, 1);
        chk("t1_pc", pc_res, 32'h40);
        chk("t1_taken", taken_res, 1);
        tick();
        chk("t1_empty", enable_res, 0);

        // Test 2: fill with back-pressure, fifth push dropped, ordered drain
        upd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'(i * 4), i[0], i[0]);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("t2_qcount", q_count, 4);
        chk("t2_drop", drop_cnt, 1);
        upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_pc", pc_res, 32'(i * 4));
            tick();
        end
        chk("t2_empty", enable_res, 0);

        // Test 3: full queue with simultaneous pop and push
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h100 + 32'(i * 4), 0, 0);
            tick();
        end
        upd_ready = 1'b1;
        drive(1, 32'h20, 1, 1);
        tick();
        drive(0, 0, 0, 0);
        upd_ready = 1'b0;
        chk("t3_qcount", q_count, 4);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_head", pc_res, 32'h104);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_flushed", q_count, 0);

        // Test 4: flush with br_valid on a 3-entry queue
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h200 + 32'(i * 4), 1, 1);
            tick();
        end
        chk("t4_qcount3", q_count, 3);
        flush = 1'b1;
        upd_ready = 1'b1;
        drive(1, 32'h300, 1, 1);
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0);
        chk("t4_enable", enable_res, 0);
        chk("t4_qcount", q_count, 0);
        chk("t4_brcnt", br_cnt, 15);
        chk("t4_drop", drop_cnt, 1);

        // Test 5: statistics; clear cycle swallows a same-cycle increment
        clr_stats = 1'b1;
        drive(1, 32'h400, 0, 1);
        tick();
        clr_stats = 1'b0;
        chk("t5_clr_lost", br_cnt, 0);
        chk("t5_clr_mis", mispred_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h500 + 32'(i * 4), i[0], (i < 3) ? ~i[0] : i[0]);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("t5_brcnt", br_cnt, 8);
        chk("t5_mispred", mispred_cnt, 3);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("t5_brcnt0", br_cnt, 0);
        chk("t5_mis0", mispred_cnt, 0);
        chk("t5_drop0", drop_cnt, 0);

        // Test 6: long wrap-around stream, every pc emitted once in order
        for (k = 0; k < 10 && enable_res; k++) tick();
        chk("t6_predrain", enable_res, 0);
        dut_emit.delete();
        for (int i = 0; i < 2048; i++) begin
            drive(1, 32'(i * 4), i[1], i[1]);
            tick();
        end
        drive(0, 0, 0, 0);
        for (k = 0; k < 10 && enable_res; k++) tick();
        chk("t6_drained", enable_res, 0);
        chk("t6_count", dut_emit.size(), 2048);
        sz = dut_emit.size();
        for (int i = 0; i < 2048; i++) begin
            if (i < sz) chk("t6_order", dut_emit[i], 32'(i * 4));
        end
        chk("t6_drop", drop_cnt, 0);
        chk("t6_brcnt", br_cnt, 2048);

        // Reset with entries in flight: nothing emitted afterwards
        upd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h900 + 32'(i * 4), 1, 0);
            tick();
        end
        chk("t6_inflight", q_count, 3);
        RST = 1'b1;
        upd_ready = 1'b1;
        drive(1, 32'hA00, 1, 1);
        tick();
        RST = 1'b0;
        drive(0, 0, 0, 0);
        sz = dut_emit.size();
        chk("t6_rst_enable", enable_res, 0);
        chk("t6_rst_qcount", q_count, 0);
        chk("t6_rst_mis", mispred_cnt, 0);
        tick();
        chk("t6_rst_noemit", dut_emit.size(), sz);
        chk("t6_rst_enable2", enable_res, 0);

        @(negedge CLK);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
